// File: rtl/dac_stream_buffer.sv
// Multi-channel lockstep sample FIFO feeding the DAC register stage; primes to PRIME_LVL before streaming.
// Pop-to-m_data latency 1; s_ready = !full, a full buffer drops and counts writes; underrun outputs zero and re-primes.
module dac_stream_buffer #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int PRIME_LVL = 16,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ADDR_W:0]          level,
  output logic                     full,
  output logic                     empty,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         underrun_cnt,
  output logic [CNT_W-1:0]         overflow_cnt
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORD_W = NUM_CH * DATA_W;
  localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PRIME_THR = (ADDR_W+1)'(PRIME_LVL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [WORD_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic [CNT_W-1:0]    urun_cnt_q, urun_cnt_d;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic full_w, empty_w, push, pop, underrun, overflow;

  // clr masks every event so a flush cycle neither stores, pops nor counts.
  always_comb begin
    full_w   = (level_q == FULL_LVL);
    empty_w  = (level_q == '0);
    push     = s_valid && !full_w && !clr;
    overflow = s_valid && full_w && !clr;
    pop      = (state_q == ST_STREAM) && en && m_ready && !empty_w && !clr;
    underrun = (state_q == ST_STREAM) && en && m_ready && empty_w && !clr;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = en ? ST_PRIME : ST_IDLE;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_PRIME;
        ST_PRIME:  if (level_q >= PRIME_THR) state_d = ST_STREAM;
        ST_STREAM: if (underrun) state_d = ST_PRIME;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    urun_cnt_d = urun_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      m_data_d   = '0;
      m_valid_d  = 1'b0;
      urun_cnt_d = '0;
      ovf_cnt_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (underrun && urun_cnt_q != '1) urun_cnt_d = urun_cnt_q + 1'b1;
      if (overflow && ovf_cnt_q != '1)  ovf_cnt_d  = ovf_cnt_q + 1'b1;
      // Outside STREAM (including the cycle after an underrun) the DAC sees silence.
      if (pop) begin
        m_data_d  = mem_q[rd_ptr_q];
        m_valid_d = 1'b1;
      end else if (state_d != ST_STREAM) begin
        m_data_d  = '0;
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      urun_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      urun_cnt_q <= urun_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_comb begin
    s_ready      = !full_w;
    full         = full_w;
    empty        = empty_w;
    level        = level_q;
    state        = state_q;
    m_data       = m_data_q;
    m_valid      = m_valid_q;
    underrun_cnt = urun_cnt_q;
    overflow_cnt = ovf_cnt_q;
  end

endmodule

// File: tb/tb_dac_stream_buffer.sv
// Directed bench for dac_stream_buffer: expected words queued at push time, compared as they emerge.
module tb_dac_stream_buffer;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n, clr, en, s_valid, m_ready;
  logic [W-1:0]  s_data;
  logic          s_ready, m_valid, full, empty;
  logic [W-1:0]  m_data;
  logic [5:0]    level;
  logic [1:0]    state;
  logic [15:0]   underrun_cnt, overflow_cnt;

  int            checks = 0;
  int            errors = 0;
  int            n_out  = 0;
  logic [W-1:0]  exp_q[$];
  logic          rdy_prev;

  dac_stream_buffer #(
    .NUM_CH(4), .DATA_W(16), .ADDR_W(5), .PRIME_LVL(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .full(full), .empty(empty), .state(state),
    .underrun_cnt(underrun_cnt), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input int base, input int i);
    logic [W-1:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'(32'h1000 * k + base + i);
    return w;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A new output word appears exactly when m_valid follows a cycle with m_ready high.
  task automatic tick(input bit acc);
    rdy_prev = m_ready;
    if (acc) exp_q.push_back(s_data);
    @(posedge clk);
    #1;
    if (m_valid && rdy_prev) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL out_extra observed=%0h expected=none", m_data);
      end else begin
        check("out_data", m_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic push(input logic [W-1:0] d, input bit acc);
    s_valid = 1'b1;
    s_data  = d;
    tick(acc);
    s_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < bound) begin
      tick(1'b0);
      cyc++;
    end
    check("drain_left", W'(exp_q.size()), '0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, W'(state), 0);
    check({tag, "_level"}, W'(level), 0);
    check({tag, "_empty"}, W'(empty), 1);
    check({tag, "_full"}, W'(full), 0);
    check({tag, "_s_ready"}, W'(s_ready), 1);
    check({tag, "_m_valid"}, W'(m_valid), 0);
    check({tag, "_m_data"}, m_data, '0);
    check({tag, "_urun"}, W'(underrun_cnt), 0);
    check({tag, "_ovf"}, W'(overflow_cnt), 0);
  endtask

  initial begin
    // T1: reset held with random inputs
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      clr     = 1'($urandom);
      en      = 1'($urandom);
      s_valid = 1'($urandom);
      m_ready = 1'($urandom);
      s_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    check_reset_vals("t1");
    clr = 1'b0; en = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    rst_n = 1'b1;
    tick(1'b0);
    check("t1_idle", W'(state), 0);

    // T2: prime with 16 words then stream them out
    en = 1'b1;
    tick(1'b0);
    check("t2_prime", W'(state), 1);
    for (int i = 0; i < 16; i++) push(mk(0, i), 1'b1);
    check("t2_level16", W'(level), 16);
    check("t2_still_prime", W'(state), 1);
    tick(1'b0);
    check("t2_stream", W'(state), 2);
    check("t2_mvalid_pre", W'(m_valid), 0);
    m_ready = 1'b1;
    n_out = 0;
    drain(40);
    check("t2_nout", W'(n_out), 16);
    m_ready = 1'b0;
    tick(1'b0);
    check("t2_no_urun", W'(underrun_cnt), 0);

    // T3: overflow while idle, then stream the first 32
    en = 1'b0;
    tick(1'b0);
    check("t3_idle", W'(state), 0);
    for (int i = 0; i < 35; i++) push(mk(16'h100, i), i < 32);
    check("t3_level", W'(level), 32);
    check("t3_full", W'(full), 1);
    check("t3_s_ready", W'(s_ready), 0);
    check("t3_ovf", W'(overflow_cnt), 3);
    en = 1'b1;
    m_ready = 1'b1;
    n_out = 0;
    drain(60);
    check("t3_nout", W'(n_out), 32);
    tick(1'b0);
    check("t3_urun", W'(underrun_cnt), 1);
    check("t3_reprime", W'(state), 1);

    // T4: prime 16, drain with no further pushes, underrun
    for (int i = 0; i < 16; i++) push(mk(16'h200, i), 1'b1);
    check("t4_level", W'(level), 16);
    n_out = 0;
    drain(40);
    check("t4_nout", W'(n_out), 16);
    tick(1'b0);
    check("t4_urun", W'(underrun_cnt), 2);
    check("t4_state", W'(state), 1);
    check("t4_m_valid", W'(m_valid), 0);
    check("t4_m_data", m_data, '0);

    // T5: steady push+pop at level 20 across pointer wrap
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) push(mk(16'h400, i), 1'b1);
    check("t5_level_init", W'(level), 20);
    check("t5_stream", W'(state), 2);
    m_ready = 1'b1;
    s_valid = 1'b1;
    n_out = 0;
    for (int i = 20; i < 120; i++) begin
      s_data = mk(16'h400, i);
      tick(1'b1);
      check("t5_level", W'(level), 20);
    end
    s_valid = 1'b0;
    check("t5_nout_steady", W'(n_out), 100);
    drain(40);
    check("t5_nout", W'(n_out), 120);
    check("t5_ovf", W'(overflow_cnt), 3);
    check("t5_urun", W'(underrun_cnt), 2);
    m_ready = 1'b0;
    tick(1'b0);

    // T6: clr alongside push and pop
    for (int i = 0; i < 4; i++) push(mk(16'h600, i), 1'b1);
    check("t6_level4", W'(level), 4);
    clr = 1'b1; s_valid = 1'b1; s_data = mk(16'h700, 0); m_ready = 1'b1;
    tick(1'b0);
    exp_q.delete();
    clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    check("t6_level", W'(level), 0);
    check("t6_empty", W'(empty), 1);
    check("t6_urun", W'(underrun_cnt), 0);
    check("t6_ovf", W'(overflow_cnt), 0);
    check("t6_m_valid", W'(m_valid), 0);
    check("t6_state", W'(state), 1);

    // T6: asynchronous reset mid-stream
    for (int i = 0; i < 16; i++) push(mk(16'h800, i), 1'b1);
    tick(1'b0);
    check("t6b_stream", W'(state), 2);
    m_ready = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check("t6b_m_valid", W'(m_valid), 1);
    check("t6b_level", W'(level), 14);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6b_rst");
    exp_q.delete();
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0);
    check("t6b_after", W'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
